// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between bus requesters and bus_arbiter
//
// Purpose: carries the requester vector and the registered arbitration
// results (one-hot grant, encoded owner index, busy, optional preempt).
// Ports (signals):
//   req     [NREQ-1:0]  requester i holds bit i high while it wants/owns the bus
//   grant   [NREQ-1:0]  one-hot or zero owner vector
//   encoded [4:0]       owner index, 5'd31 when nobody owns the bus
//   busy                high whenever grant is nonzero
//   preempt             one-cycle forced-release pulse (BUS_ARB_TIMEOUT_EN only)
// Modports: master = requester side, slave = arbiter side.
// Macro: BUS_ARB_TIMEOUT_EN adds the preempt signal.

interface bus_arbiter_if #(
    parameter int NREQ = 24
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [4:0]      encoded;
    logic            busy;
`ifdef BUS_ARB_TIMEOUT_EN
    logic            preempt;

    modport master (output req, input grant, input encoded, input busy, input preempt);
    modport slave  (input req, output grant, output encoded, output busy, output preempt);
`else
    modport master (output req, input grant, input encoded, input busy);
    modport slave  (input req, output grant, output encoded, output busy);
`endif
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin (descending) bus arbiter with one-cycle turnaround
//
// Purpose: grants the bus to one of NREQ requesters. Search order starts at
// ptr and descends with wrap; the last owner becomes lowest priority. Every
// tenure ends with a single RELEASE turnaround cycle before re-arbitration.
// Ports:
//   clk    rising-edge clock
//   clear  asynchronous active-low reset
//   bus    bus_arbiter_if.slave (req in; grant/encoded/busy[/preempt] out, all registered)
// Parameters:
//   NREQ      number of requesters (encoded is 5 bits, so at most 31)
//   MAX_HOLD  maximum tenure in cycles while another requester waits (2..255)
// Macro: BUS_ARB_TIMEOUT_EN enables the tenure counter, forced release and preempt.

module bus_arbiter #(
    parameter int NREQ     = 24,
    parameter int MAX_HOLD = 8
) (
    input logic          clk,
    input logic          clear,
    bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [4:0] ENC_NONE = 5'd31;
    localparam logic [4:0] PTR_TOP  = 5'(NREQ - 1);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [4:0]      encoded_q, encoded_d;
    logic            busy_q, busy_d;
    logic [4:0]      ptr_q, ptr_d;

    logic            any_req;
    logic [4:0]      win_idx;
    logic            owner_req;
    logic [4:0]      ptr_after_owner;
    int              cand;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] tenure_q, tenure_d;
    logic       preempt_q, preempt_d;
    logic       others_waiting;

    // grant_q is the owner's one-hot, so masking it leaves only competitors
    assign others_waiting = |(bus.req & ~grant_q);
`endif

    // While in GRANT, encoded_q is the owner index
    assign owner_req       = bus.req[encoded_q];
    assign ptr_after_owner = (encoded_q == 5'd0) ? PTR_TOP : encoded_q - 5'd1;

    // Descending search from ptr with wrap; the first high req wins
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) - i;
            if (cand < 0) begin
                cand = cand + NREQ;
            end
            if (!any_req && bus.req[cand[4:0]]) begin
                any_req = 1'b1;
                win_idx = cand[4:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        encoded_d = encoded_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        tenure_d  = tenure_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            // RELEASE is the turnaround cycle; it arbitrates exactly like IDLE
            IDLE, RELEASE: begin
                state_d   = IDLE;
                grant_d   = '0;
                encoded_d = ENC_NONE;
                busy_d    = 1'b0;
                if (any_req) begin
                    state_d   = GRANT;
                    grant_d   = NREQ'(1) << win_idx;
                    encoded_d = win_idx;
                    busy_d    = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                    tenure_d  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    encoded_d = ENC_NONE;
                    busy_d    = 1'b0;
                    ptr_d     = ptr_after_owner;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                // A voluntary release at the same edge takes the branch above,
                // so preempt only fires when the owner is still requesting
                else if (tenure_q == HOLD_LAST && others_waiting) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    encoded_d = ENC_NONE;
                    busy_d    = 1'b0;
                    ptr_d     = ptr_after_owner;
                    preempt_d = 1'b1;
                end else begin
                    tenure_d = (tenure_q == 8'hFF) ? tenure_q : tenure_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                grant_d   = '0;
                encoded_d = ENC_NONE;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            encoded_q <= ENC_NONE;
            busy_q    <= 1'b0;
            ptr_q     <= PTR_TOP;
`ifdef BUS_ARB_TIMEOUT_EN
            tenure_q  <= 8'd0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            encoded_q <= encoded_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
`ifdef BUS_ARB_TIMEOUT_EN
            tenure_q  <= tenure_d;
            preempt_q <= preempt_d;
`endif
        end
    end

    assign bus.grant   = grant_q;
    assign bus.encoded = encoded_q;
    assign bus.busy    = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign bus.preempt = preempt_q;
`endif

endmodule
